// File: rtl/vai_rx_demux.sv
// ----------------------------------------------------------------------------
// vai_rx_demux
//
// Response-path demultiplexer for a group of sub-AFUs sharing one CCI-P port.
// Every read (c0) and write (c1) response from the single upstream Rx port is
// steered to the sub-AFU that issued it. The owner is the AFU-ID tag that the
// Tx multiplexer placed in mdata[15:12]. The tag is cleared before delivery.
// Almost-full flags are fanned out to every sub-AFU. A per-AFU count of
// outstanding lines lets the manager spot orphaned or spurious responses.
//
// Ports
//   pClk, SoftReset   clock and synchronous active-high reset
//   up_RxPort         upstream CCI-P Rx port (responses, MMIO, almost-full)
//   afu_RxPort[i]     per-sub-AFU Rx port (2-cycle data latency, 1-cycle
//                     almost-full latency, MMIO valids always 0)
//   tx_c0_issue/afu/lines  read issued upstream: owner and line count
//   tx_c1_issue/afu        write issued upstream: owner
//   outstanding[i]    outstanding lines per sub-AFU (saturating)
//   err_bad_id        sticky: a response carried a tag >= NUM_SUB_AFUS
//   err_underflow[i]  sticky: counter i would have gone negative
//   err_overflow[i]   sticky: counter i saturated at all-ones
//   rsp_count[i]      (only with VAI_RX_DEMUX_STATS_EN) delivered responses
//
// Handshake: rspValid is a single-cycle qualifier with no backpressure. A
// response is delivered in exactly the cycle its valid is high. Almost-full is
// advisory flow control toward the issuing side.
//
// Optional feature macro: VAI_RX_DEMUX_STATS_EN adds rsp_count.
// ----------------------------------------------------------------------------
package ccip_if_pkg;
    typedef logic [511:0] t_ccip_clData;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
endpackage

module vai_rx_demux
    import ccip_if_pkg::*;
#(
    parameter int NUM_SUB_AFUS = 9,
    parameter int CNT_W        = 10
) (
    input  logic                                pClk,
    input  logic                                SoftReset,
    input  t_if_ccip_Rx                         up_RxPort,
    output t_if_ccip_Rx [NUM_SUB_AFUS-1:0]      afu_RxPort,
    input  logic                                tx_c0_issue,
    input  logic [3:0]                          tx_c0_afu,
    input  logic [2:0]                          tx_c0_lines,
    input  logic                                tx_c1_issue,
    input  logic [3:0]                          tx_c1_afu,
    output logic [NUM_SUB_AFUS-1:0][CNT_W-1:0]  outstanding,
    output logic                                err_bad_id,
    output logic [NUM_SUB_AFUS-1:0]             err_underflow,
    output logic [NUM_SUB_AFUS-1:0]             err_overflow
`ifdef VAI_RX_DEMUX_STATS_EN
    ,
    output logic [NUM_SUB_AFUS-1:0][31:0]       rsp_count
`endif
);
    // Two guard bits: one for carries past all-ones, one as the sign.
    localparam int SW = CNT_W + 2;

    // MMIO belongs to the manager; those valids are deliberately dropped here.
    logic w_unused_mmio;
    assign w_unused_mmio = up_RxPort.c0.mmioRdValid | up_RxPort.c0.mmioWrValid;

    // ---------------- stage 1: capture ----------------
    t_ccip_c0_RspMemHdr r_s1_c0_hdr;
    t_ccip_clData       r_s1_c0_data;
    logic               r_s1_c0_vld;
    t_ccip_c1_RspMemHdr r_s1_c1_hdr;
    logic               r_s1_c1_vld;
    logic               r_alm0;
    logic               r_alm1;

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            r_s1_c0_hdr  <= '0;
            r_s1_c0_data <= '0;
            r_s1_c0_vld  <= 1'b0;
            r_s1_c1_hdr  <= '0;
            r_s1_c1_vld  <= 1'b0;
            r_alm0       <= 1'b0;
            r_alm1       <= 1'b0;
        end else begin
            r_s1_c0_hdr  <= up_RxPort.c0.hdr;
            r_s1_c0_data <= up_RxPort.c0.data;
            r_s1_c0_vld  <= up_RxPort.c0.rspValid;
            r_s1_c1_hdr  <= up_RxPort.c1.hdr;
            r_s1_c1_vld  <= up_RxPort.c1.rspValid;
            r_alm0       <= up_RxPort.c0TxAlmFull;
            r_alm1       <= up_RxPort.c1TxAlmFull;
        end
    end

    // ---------------- owner decode ----------------
    logic [3:0]              w_id0;
    logic [3:0]              w_id1;
    logic [NUM_SUB_AFUS-1:0] w_sel0;
    logic [NUM_SUB_AFUS-1:0] w_sel1;
    logic                    w_bad0;
    logic                    w_bad1;
    t_ccip_c0_RspMemHdr      w_c0_hdr_clr;
    t_ccip_c1_RspMemHdr      w_c1_hdr_clr;
    logic [2:0]              w_dec1_amt;

    assign w_id0 = r_s1_c0_hdr.mdata[15:12];
    assign w_id1 = r_s1_c1_hdr.mdata[15:12];

    always_comb begin
        w_sel0 = '0;
        w_sel1 = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            w_sel0[i] = r_s1_c0_vld && (w_id0 == 4'(i));
            w_sel1[i] = r_s1_c1_vld && (w_id1 == 4'(i));
        end
    end

    // A valid response that selects no port carries an out-of-range tag.
    assign w_bad0 = r_s1_c0_vld && (w_sel0 == '0);
    assign w_bad1 = r_s1_c1_vld && (w_sel1 == '0);

    always_comb begin
        w_c0_hdr_clr             = r_s1_c0_hdr;
        w_c0_hdr_clr.mdata[15:12] = 4'h0;
        w_c1_hdr_clr             = r_s1_c1_hdr;
        w_c1_hdr_clr.mdata[15:12] = 4'h0;
    end

    // A packed write response acknowledges cl_num+1 lines at once.
    assign w_dec1_amt = r_s1_c1_hdr.format ? ({1'b0, r_s1_c1_hdr.cl_num} + 3'd1) : 3'd1;

    // ---------------- stage 2: delivery ----------------
    t_ccip_c0_RspMemHdr      r_s2_c0_hdr;
    t_ccip_clData            r_s2_c0_data;
    t_ccip_c1_RspMemHdr      r_s2_c1_hdr;
    logic [NUM_SUB_AFUS-1:0] r_s2_c0_sel;
    logic [NUM_SUB_AFUS-1:0] r_s2_c1_sel;

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            r_s2_c0_hdr  <= '0;
            r_s2_c0_data <= '0;
            r_s2_c1_hdr  <= '0;
            r_s2_c0_sel  <= '0;
            r_s2_c1_sel  <= '0;
        end else begin
            r_s2_c0_hdr  <= w_c0_hdr_clr;
            r_s2_c0_data <= r_s1_c0_data;
            r_s2_c1_hdr  <= w_c1_hdr_clr;
            r_s2_c0_sel  <= w_sel0;
            r_s2_c1_sel  <= w_sel1;
        end
    end

    // Header and data are broadcast; only the owner sees a valid.
    always_comb begin
        afu_RxPort = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            afu_RxPort[i].c0TxAlmFull = r_alm0;
            afu_RxPort[i].c1TxAlmFull = r_alm1;
            afu_RxPort[i].c0.hdr      = r_s2_c0_hdr;
            afu_RxPort[i].c0.data     = r_s2_c0_data;
            afu_RxPort[i].c0.rspValid = r_s2_c0_sel[i];
            afu_RxPort[i].c1.hdr      = r_s2_c1_hdr;
            afu_RxPort[i].c1.rspValid = r_s2_c1_sel[i];
        end
    end

    // ---------------- outstanding-line counters ----------------
    // Decrements use the stage-1 selects so they land on the same edge that
    // makes the response visible downstream. Issue IDs outside the AFU range
    // match no index and are ignored.
    logic [NUM_SUB_AFUS-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_SUB_AFUS-1:0]            r_under;
    logic [NUM_SUB_AFUS-1:0]            r_over;
    logic                               r_bad;
    logic [NUM_SUB_AFUS-1:0][SW-1:0]    w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            w_sum[i] = {2'b00, r_cnt[i]};
            if (tx_c0_issue && (tx_c0_afu == 4'(i))) w_sum[i] = w_sum[i] + SW'(tx_c0_lines);
            if (tx_c1_issue && (tx_c1_afu == 4'(i))) w_sum[i] = w_sum[i] + SW'(1);
            if (w_sel0[i])                           w_sum[i] = w_sum[i] - SW'(1);
            if (w_sel1[i])                           w_sum[i] = w_sum[i] - SW'(w_dec1_amt);
        end
    end

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            r_cnt   <= '0;
            r_under <= '0;
            r_over  <= '0;
            r_bad   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                if (w_sum[i][SW-1]) begin
                    r_cnt[i]   <= '0;
                    r_under[i] <= 1'b1;
                end else if (w_sum[i][CNT_W]) begin
                    r_cnt[i]  <= '1;
                    r_over[i] <= 1'b1;
                end else begin
                    r_cnt[i] <= w_sum[i][CNT_W-1:0];
                end
            end
            r_bad <= r_bad | w_bad0 | w_bad1;
        end
    end

    assign outstanding   = r_cnt;
    assign err_underflow = r_under;
    assign err_overflow  = r_over;
    assign err_bad_id    = r_bad;

`ifdef VAI_RX_DEMUX_STATS_EN
    logic [NUM_SUB_AFUS-1:0][31:0] r_rsp_count;

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            r_rsp_count <= '0;
        end else begin
            for (int i = 0; i < NUM_SUB_AFUS; i++) begin
                r_rsp_count[i] <= r_rsp_count[i] + 32'(w_sel0[i]) + 32'(w_sel1[i]);
            end
        end
    end

    assign rsp_count = r_rsp_count;
`endif

endmodule

// File: tb/tb_vai_rx_demux.sv
`timescale 1ns/1ps
module tb_vai_rx_demux;
    import ccip_if_pkg::*;

    localparam int NUM   = 9;
    localparam int CNT_W = 10;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    t_if_ccip_Rx                 up;
    t_if_ccip_Rx [NUM-1:0]       afu;
    logic                        tx_c0_issue;
    logic [3:0]                  tx_c0_afu;
    logic [2:0]                  tx_c0_lines;
    logic                        tx_c1_issue;
    logic [3:0]                  tx_c1_afu;
    logic [NUM-1:0][CNT_W-1:0]   outstanding;
    logic                        err_bad_id;
    logic [NUM-1:0]              err_underflow;
    logic [NUM-1:0]              err_overflow;
`ifdef VAI_RX_DEMUX_STATS_EN
    logic [NUM-1:0][31:0]        rsp_count;
`endif

    vai_rx_demux #(.NUM_SUB_AFUS(NUM), .CNT_W(CNT_W)) dut (
        .pClk          (clk),
        .SoftReset     (rst),
        .up_RxPort     (up),
        .afu_RxPort    (afu),
        .tx_c0_issue   (tx_c0_issue),
        .tx_c0_afu     (tx_c0_afu),
        .tx_c0_lines   (tx_c0_lines),
        .tx_c1_issue   (tx_c1_issue),
        .tx_c1_afu     (tx_c1_afu),
        .outstanding   (outstanding),
        .err_bad_id    (err_bad_id),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
`ifdef VAI_RX_DEMUX_STATS_EN
        ,
        .rsp_count     (rsp_count)
`endif
    );

    // ---------------- reference model ----------------
    // Each upstream response becomes visible downstream one edge after the
    // edge that samples it, so exp_q never holds more than one record.
    typedef struct packed {
        logic               c0v;
        t_ccip_c0_RspMemHdr c0hdr;
        t_ccip_clData       c0data;
        logic               c1v;
        t_ccip_c1_RspMemHdr c1hdr;
    } t_rec;

    t_rec            exp_q[$];
    t_rec            m_del;
    int              m_out   [NUM];
    int unsigned     m_stats [NUM];
    bit              m_bad;
    bit [NUM-1:0]    m_under;
    bit [NUM-1:0]    m_over;
    bit              m_alm0;
    bit              m_alm1;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        up          = '0;
        tx_c0_issue = 1'b0;
        tx_c0_afu   = 4'h0;
        tx_c0_lines = 3'd0;
        tx_c1_issue = 1'b0;
        tx_c1_afu   = 4'h0;
    endtask

    function automatic t_ccip_clData rand_data();
        t_ccip_clData d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [3:0] pick_id();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(NUM, 15));
        return 4'($urandom_range(0, NUM - 1));
    endfunction

    function automatic logic [NUM-1:0] c0_valids();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = afu[i].c0.rspValid;
        return v;
    endfunction

    function automatic logic [NUM-1:0] c1_valids();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = afu[i].c1.rspValid;
        return v;
    endfunction

    function automatic logic [NUM-1:0] alm0_vec();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = afu[i].c0TxAlmFull;
        return v;
    endfunction

    // Advance one clock and update the model to what should be visible after
    // that edge. Returns #1 after the edge, ready for sampling and re-driving.
    task automatic tick();
        t_rec       cur;
        t_rec       del;
        bit         r, i0, i1, a0, a1;
        logic [3:0] af0, af1;
        logic [2:0] ln;
        int         n, dl;
        cur.c0v    = up.c0.rspValid;
        cur.c0hdr  = up.c0.hdr;
        cur.c0data = up.c0.data;
        cur.c1v    = up.c1.rspValid;
        cur.c1hdr  = up.c1.hdr;
        r   = rst;
        i0  = tx_c0_issue; af0 = tx_c0_afu; ln = tx_c0_lines;
        i1  = tx_c1_issue; af1 = tx_c1_afu;
        a0  = up.c0TxAlmFull; a1 = up.c1TxAlmFull;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_del   = '0;
            m_alm0  = 1'b0;
            m_alm1  = 1'b0;
            m_bad   = 1'b0;
            m_under = '0;
            m_over  = '0;
            for (int i = 0; i < NUM; i++) begin
                m_out[i]   = 0;
                m_stats[i] = 0;
            end
        end else begin
            del = '0;
            if (exp_q.size() > 0) del = exp_q.pop_front();
            exp_q.push_back(cur);
            m_del  = del;
            m_alm0 = a0;
            m_alm1 = a1;
            for (int i = 0; i < NUM; i++) begin
                n = m_out[i];
                if (i0 && int'(af0) == i) n += int'(ln);
                if (i1 && int'(af1) == i) n += 1;
                if (del.c0v && int'(del.c0hdr.mdata[15:12]) == i) begin
                    n -= 1;
                    m_stats[i]++;
                end
                if (del.c1v && int'(del.c1hdr.mdata[15:12]) == i) begin
                    dl = del.c1hdr.format ? int'(del.c1hdr.cl_num) + 1 : 1;
                    n -= dl;
                    m_stats[i]++;
                end
                if (n < 0) begin
                    m_out[i]   = 0;
                    m_under[i] = 1'b1;
                end else if (n > CMAX) begin
                    m_out[i]  = CMAX;
                    m_over[i] = 1'b1;
                end else begin
                    m_out[i] = n;
                end
            end
            if (del.c0v && int'(del.c0hdr.mdata[15:12]) >= NUM) m_bad = 1'b1;
            if (del.c1v && int'(del.c1hdr.mdata[15:12]) >= NUM) m_bad = 1'b1;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (afu !== '0)
            $display("FAIL reset_afu_rx: got %0d bits set expected 0", $countones(afu));
        n_cmp++;
        if (outstanding !== '0) $display("FAIL reset_outstanding: got %0h expected 0", outstanding);
        n_cmp++;
        if ({err_bad_id, err_underflow, err_overflow} !== '0)
            $display("FAIL reset_errs: got %0b/%0h/%0h expected 0/0/0", err_bad_id, err_underflow, err_overflow);
        if (afu !== '0 || outstanding !== '0 || {err_bad_id, err_underflow, err_overflow} !== '0) n_err++;
    endtask

    task automatic test_read_routing();
        t_ccip_clData d;
        clear_inputs();
        tx_c0_issue = 1'b1; tx_c0_afu = 4'd3; tx_c0_lines = 3'd1;
        tick();
        clear_inputs();
        n_cmp++;
        if (outstanding[3] !== 10'd1) begin
            n_err++; $display("FAIL rd_issue_cnt: got %0d expected 1", outstanding[3]);
        end
        d = rand_data();
        up.c0.rspValid = 1'b1; up.c0.hdr.mdata = 16'h3ABC; up.c0.data = d;
        tick();
        clear_inputs();
        n_cmp++;
        if (c0_valids() !== '0) begin
            n_err++; $display("FAIL rd_early_valid: got %0b expected 0", c0_valids());
        end
        tick();
        n_cmp++;
        if (c0_valids() !== 9'b000001000) begin
            n_err++; $display("FAIL rd_route_valids: got %09b expected 000001000", c0_valids());
        end
        n_cmp++;
        if (afu[3].c0.hdr.mdata !== 16'h0ABC) begin
            n_err++; $display("FAIL rd_mdata: got %0h expected 0abc", afu[3].c0.hdr.mdata);
        end
        n_cmp++;
        if (afu[3].c0.data !== d) begin
            n_err++; $display("FAIL rd_data: got %0h expected %0h", afu[3].c0.data, d);
        end
        n_cmp++;
        if (outstanding[3] !== 10'd0) begin
            n_err++; $display("FAIL rd_cnt_dec: got %0d expected 0", outstanding[3]);
        end
        tick();
        n_cmp++;
        if (c0_valids() !== '0) begin
            n_err++; $display("FAIL rd_valid_single: got %0b expected 0", c0_valids());
        end
    endtask

    task automatic test_concurrent();
        clear_inputs();
        tx_c0_issue = 1'b1; tx_c0_afu = 4'd5; tx_c0_lines = 3'd4;
        tx_c1_issue = 1'b1; tx_c1_afu = 4'd5;
        tick();
        clear_inputs();
        n_cmp++;
        if (outstanding[5] !== 10'd5) begin
            n_err++; $display("FAIL cc_issue_cnt: got %0d expected 5", outstanding[5]);
        end
        up.c0.rspValid = 1'b1; up.c0.hdr.mdata = 16'h5001;
        up.c1.rspValid = 1'b1; up.c1.hdr.mdata = 16'h5002;
        up.c1.hdr.format = 1'b1; up.c1.hdr.cl_num = 2'd0;
        tick();
        clear_inputs();
        tick();
        n_cmp++;
        if ({c0_valids(), c1_valids()} !== {9'b000100000, 9'b000100000}) begin
            n_err++; $display("FAIL cc_valids: got %09b/%09b expected 000100000/000100000", c0_valids(), c1_valids());
        end
        n_cmp++;
        if ({afu[5].c0.hdr.mdata, afu[5].c1.hdr.mdata} !== {16'h0001, 16'h0002}) begin
            n_err++; $display("FAIL cc_mdata: got %0h/%0h expected 1/2", afu[5].c0.hdr.mdata, afu[5].c1.hdr.mdata);
        end
        n_cmp++;
        if (outstanding[5] !== 10'd3) begin
            n_err++; $display("FAIL cc_cnt: got %0d expected 3", outstanding[5]);
        end
    endtask

    task automatic test_bad_id();
        logic [NUM-1:0][CNT_W-1:0] snap;
        clear_inputs();
        snap = outstanding;
        up.c1.rspValid = 1'b1; up.c1.hdr.mdata = 16'hF000;
        tick();
        clear_inputs();
        tick();
        n_cmp++;
        if ({c0_valids(), c1_valids()} !== '0) begin
            n_err++; $display("FAIL bad_valids: got %0b/%0b expected 0/0", c0_valids(), c1_valids());
        end
        n_cmp++;
        if (err_bad_id !== 1'b1) begin
            n_err++; $display("FAIL bad_flag: got %0b expected 1", err_bad_id);
        end
        n_cmp++;
        if (outstanding !== snap) begin
            n_err++; $display("FAIL bad_cnt: got %0h expected %0h", outstanding, snap);
        end
        repeat (3) tick();
        n_cmp++;
        if (err_bad_id !== 1'b1) begin
            n_err++; $display("FAIL bad_sticky: got %0b expected 1", err_bad_id);
        end
    endtask

    task automatic test_underflow();
        clear_inputs();
        n_cmp++;
        if (outstanding[0] !== 10'd0) begin
            n_err++; $display("FAIL uf_pre: got %0d expected 0", outstanding[0]);
        end
        up.c0.rspValid = 1'b1; up.c0.hdr.mdata = 16'h0123;
        tick();
        clear_inputs();
        tick();
        n_cmp++;
        if (c0_valids() !== 9'b000000001) begin
            n_err++; $display("FAIL uf_valids: got %09b expected 000000001", c0_valids());
        end
        n_cmp++;
        if (outstanding[0] !== 10'd0) begin
            n_err++; $display("FAIL uf_cnt: got %0d expected 0", outstanding[0]);
        end
        n_cmp++;
        if (err_underflow !== 9'h001) begin
            n_err++; $display("FAIL uf_flag: got %0h expected 001", err_underflow);
        end
    endtask

    task automatic test_mmio_almfull();
        logic [NUM-1:0][CNT_W-1:0] snap;
        clear_inputs();
        snap = outstanding;
        up.c0.mmioWrValid = 1'b1; up.c0.hdr.mdata = 16'h1234; up.c0TxAlmFull = 1'b1;
        tick();
        clear_inputs();
        n_cmp++;
        if (alm0_vec() !== 9'h1FF) begin
            n_err++; $display("FAIL alm_fanout: got %0h expected 1ff", alm0_vec());
        end
        n_cmp++;
        if (afu[4].c1TxAlmFull !== 1'b0) begin
            n_err++; $display("FAIL alm_c1: got %0b expected 0", afu[4].c1TxAlmFull);
        end
        tick();
        n_cmp++;
        if ({c0_valids(), afu[1].c0.mmioWrValid, afu[1].c0.mmioRdValid} !== '0) begin
            n_err++; $display("FAIL mmio_blocked: got %0b/%0b expected 0/0", c0_valids(), afu[1].c0.mmioWrValid);
        end
        n_cmp++;
        if (outstanding !== snap) begin
            n_err++; $display("FAIL mmio_cnt: got %0h expected %0h", outstanding, snap);
        end
        n_cmp++;
        if (alm0_vec() !== '0) begin
            n_err++; $display("FAIL alm_release: got %0h expected 0", alm0_vec());
        end
    endtask

    task automatic test_overflow();
        clear_inputs();
        repeat (255) begin
            tx_c0_issue = 1'b1; tx_c0_afu = 4'd7; tx_c0_lines = 3'd4;
            tick();
        end
        clear_inputs();
        n_cmp++;
        if ({outstanding[7], err_overflow} !== {10'd1020, 9'h000}) begin
            n_err++; $display("FAIL of_pre: got %0d/%0h expected 1020/0", outstanding[7], err_overflow);
        end
        tx_c0_issue = 1'b1; tx_c0_afu = 4'd7; tx_c0_lines = 3'd4;
        tick();
        clear_inputs();
        n_cmp++;
        if (outstanding[7] !== 10'd1023) begin
            n_err++; $display("FAIL of_sat: got %0d expected 1023", outstanding[7]);
        end
        n_cmp++;
        if (err_overflow !== 9'h080) begin
            n_err++; $display("FAIL of_flag: got %0h expected 080", err_overflow);
        end
        // An out-of-range issue must not touch any counter.
        tx_c1_issue = 1'b1; tx_c1_afu = 4'd12;
        tick();
        clear_inputs();
        n_cmp++;
        if (outstanding[7] !== 10'd1023 || outstanding[0] !== 10'd0) begin
            n_err++; $display("FAIL issue_bad_id: got %0d/%0d expected 1023/0", outstanding[7], outstanding[0]);
        end
    endtask

    task automatic test_random();
        t_ccip_c0_RspMemHdr eh0;
        t_ccip_c1_RspMemHdr eh1;
        bit e0, e1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_inputs();
            up.c0TxAlmFull = ($urandom_range(0, 3) == 0);
            up.c1TxAlmFull = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                up.c0.rspValid        = 1'b1;
                up.c0.hdr             = 28'($urandom);
                up.c0.hdr.mdata[15:12] = pick_id();
                up.c0.data            = rand_data();
            end
            if ($urandom_range(0, 9) == 0) up.c0.mmioRdValid = 1'b1;
            if ($urandom_range(0, 9) == 0) up.c0.mmioWrValid = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                up.c1.rspValid        = 1'b1;
                up.c1.hdr             = 28'($urandom);
                up.c1.hdr.mdata[15:12] = pick_id();
            end
            tx_c0_issue = ($urandom_range(0, 1) == 1);
            tx_c0_afu   = pick_id();
            tx_c0_lines = 3'(1 << $urandom_range(0, 2));
            tx_c1_issue = ($urandom_range(0, 2) == 0);
            tx_c1_afu   = pick_id();
            tick();
            for (int i = 0; i < NUM; i++) begin
                e0 = m_del.c0v && (int'(m_del.c0hdr.mdata[15:12]) == i);
                e1 = m_del.c1v && (int'(m_del.c1hdr.mdata[15:12]) == i);
                eh0 = m_del.c0hdr; eh0.mdata[15:12] = 4'h0;
                eh1 = m_del.c1hdr; eh1.mdata[15:12] = 4'h0;
                n_cmp++;
                if ({afu[i].c0.rspValid, afu[i].c1.rspValid} !== {e0, e1}) begin
                    n_err++; $display("FAIL rnd_valid cyc %0d afu %0d: got %0b%0b expected %0b%0b",
                        cyc, i, afu[i].c0.rspValid, afu[i].c1.rspValid, e0, e1);
                end
                if (e0) begin
                    n_cmp++;
                    if (afu[i].c0.hdr !== eh0 || afu[i].c0.data !== m_del.c0data) begin
                        n_err++; $display("FAIL rnd_c0_payload cyc %0d afu %0d: got hdr %0h expected hdr %0h",
                            cyc, i, afu[i].c0.hdr, eh0);
                    end
                end
                if (e1) begin
                    n_cmp++;
                    if (afu[i].c1.hdr !== eh1) begin
                        n_err++; $display("FAIL rnd_c1_hdr cyc %0d afu %0d: got %0h expected %0h",
                            cyc, i, afu[i].c1.hdr, eh1);
                    end
                end
                n_cmp++;
                if ({afu[i].c0TxAlmFull, afu[i].c1TxAlmFull, afu[i].c0.mmioRdValid, afu[i].c0.mmioWrValid}
                        !== {m_alm0, m_alm1, 2'b00}) begin
                    n_err++; $display("FAIL rnd_alm_mmio cyc %0d afu %0d: got %0b%0b%0b%0b expected %0b%0b00",
                        cyc, i, afu[i].c0TxAlmFull, afu[i].c1TxAlmFull, afu[i].c0.mmioRdValid,
                        afu[i].c0.mmioWrValid, m_alm0, m_alm1);
                end
                n_cmp++;
                if (outstanding[i] !== CNT_W'(m_out[i])) begin
                    n_err++; $display("FAIL rnd_cnt cyc %0d afu %0d: got %0d expected %0d",
                        cyc, i, outstanding[i], m_out[i]);
                end
`ifdef VAI_RX_DEMUX_STATS_EN
                n_cmp++;
                if (rsp_count[i] !== m_stats[i]) begin
                    n_err++; $display("FAIL rnd_stats cyc %0d afu %0d: got %0d expected %0d",
                        cyc, i, rsp_count[i], m_stats[i]);
                end
`endif
            end
            n_cmp++;
            if ({err_bad_id, err_underflow, err_overflow} !== {m_bad, m_under, m_over}) begin
                n_err++; $display("FAIL rnd_errs cyc %0d: got %0b/%0h/%0h expected %0b/%0h/%0h",
                    cyc, err_bad_id, err_underflow, err_overflow, m_bad, m_under, m_over);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        clear_inputs();
        up.c0.rspValid = 1'b1; up.c0.hdr.mdata = 16'h2055; up.c0.data = rand_data();
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (afu[2].c0.rspValid !== 1'b0) begin
            n_err++; $display("FAIL mid_valid_at_reset: got %0b expected 0", afu[2].c0.rspValid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (afu[2].c0.rspValid !== 1'b0) begin
                n_err++; $display("FAIL mid_valid_after %0d: got %0b expected 0", k, afu[2].c0.rspValid);
            end
        end
        n_cmp++;
        if (afu !== '0) begin
            n_err++; $display("FAIL mid_afu_zero: got %0d bits set expected 0", $countones(afu));
        end
        n_cmp++;
        if ({outstanding, err_bad_id, err_underflow, err_overflow} !== '0) begin
            n_err++; $display("FAIL mid_state_zero: got %0h/%0b/%0h/%0h expected 0",
                outstanding, err_bad_id, err_underflow, err_overflow);
        end
`ifdef VAI_RX_DEMUX_STATS_EN
        n_cmp++;
        if (rsp_count[2] !== 32'd0) begin
            n_err++; $display("FAIL mid_stats: got %0d expected 0", rsp_count[2]);
        end
`endif
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        m_del = '0;
        test_reset();
        test_read_routing();
        test_concurrent();
        test_bad_id();
        test_underflow();
        test_mmio_almfull();
        test_overflow();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vai_rx_demux.md
Name: vai_rx_demux

Overview:
- Response-path counterpart of the sub-AFU Tx multiplexer.
- Takes the single upstream CCI-P Rx port and steers each read response (c0) and write response (c1) to the sub-AFU that issued it. The owner is decoded from the AFU-ID tag that the Tx path writes into mdata[15:12].
- Before delivery it clears the tag, fans almost-full to every sub-AFU, and tracks per-AFU outstanding lines so the manager can detect orphaned or spurious responses.

Parameters:
- NUM_SUB_AFUS, 9, number of downstream sub-AFUs; legal range 1..16.
- CNT_W, 10, width of each per-AFU outstanding-line counter.

Ports:
- pClk  in  1  clock.
- SoftReset  in  1  synchronous, active-high reset.
- up_RxPort  in  t_if_ccip_Rx  upstream Rx response port.
- afu_RxPort  out  t_if_ccip_Rx [NUM_SUB_AFUS-1:0]  per-sub-AFU Rx port.
- tx_c0_issue  in  1  pulse: read request accepted upstream.
- tx_c0_afu  in  4  AFU ID of that read.
- tx_c0_lines  in  3  lines requested (1, 2 or 4).
- tx_c1_issue  in  1  pulse: write request accepted upstream.
- tx_c1_afu  in  4  AFU ID of that write.
- outstanding  out  CNT_W [NUM_SUB_AFUS-1:0]  outstanding lines per AFU.
- err_bad_id  out  1  sticky: response tag >= NUM_SUB_AFUS.
- err_underflow  out  NUM_SUB_AFUS  sticky, per AFU: response with counter at 0.
- err_overflow  out  NUM_SUB_AFUS  sticky, per AFU: counter saturated.

Behaviour:
- Reset:
  - All afu_RxPort fields are 0, including valids and almost-fulls.
  - outstanding = 0.
  - All err_* = 0.
  - Pipeline valids are cleared. In-flight responses are discarded, not delivered.
- Almost-full: c0TxAlmFull and c1TxAlmFull are registered once (1-cycle latency) and driven identically to every afu_RxPort[i].
- Data path, 2-cycle latency from up_RxPort to afu_RxPort:
  - Stage 1 registers the c0 and c1 headers, data and valids. It decodes id0 = c0.hdr.mdata[15:12] and id1 = c1.hdr.mdata[15:12].
  - Stage 2 asserts rspValid only on afu_RxPort[id], with mdata[15:12] forced to 0. All other header and data fields are copied unchanged.
  - Non-target AFUs see valid = 0. Their hdr/data fields may mirror the broadcast value.
- MMIO: c0.mmioRdValid and c0.mmioWrValid are never forwarded; MMIO is owned by the manager. A c0 cycle carrying only MMIO produces no downstream valid and no counter change.
- c0 and c1 responses in the same cycle are independent. They may target the same AFU, and both are delivered in the same cycle on their respective channels.
- Bad ID: if id >= NUM_SUB_AFUS, the response is dropped, err_bad_id is set, and no counter changes.
- Counters:
  - Read issue: outstanding[tx_c0_afu] += tx_c0_lines.
  - Write issue: outstanding[tx_c1_afu] += 1.
  - c0 read response: -1 per response (one per line).
  - c1 write response: -(cl_num+1) if hdr.format = 1 (packed), else -1.
  - Per AFU per cycle: next = cur + inc0 + inc1 - dec0 - dec1, computed at CNT_W+2 bits signed.
  - Result < 0: counter holds 0 and err_underflow[i] is set.
  - Result > 2^CNT_W - 1: counter saturates at all-ones and err_overflow[i] is set.
  - Decrements are applied at stage 2, aligned with delivery. Increments are applied the cycle after the issue pulse.
  - Issue pulses with afu >= NUM_SUB_AFUS are ignored.
- All error flags are sticky until SoftReset.

Optional Feature:
- Macro: VAI_RX_DEMUX_STATS_EN.
- Defined:
  - Adds output port rsp_count, 32 x NUM_SUB_AFUS: per-AFU delivered-response counters, incremented once per delivered c0 or c1 response.
  - Two responses to the same AFU in one cycle add 2.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Read response routing: reset, issue read afu=3 lines=1, then c0 rspValid with mdata=0x3ABC -> after exactly 2 cycles afu_RxPort[3].c0.rspValid=1 with mdata=0x0ABC. All other AFUs valid=0. outstanding[3] goes 1 -> 0.
- Concurrent channels, same AFU: issue write afu=5 and read afu=5 lines=4, then c0 rsp (mdata 0x5001) and packed c1 rsp (mdata 0x5002, format=1, cl_num=0) in the same cycle -> both delivered to AFU 5 in the same cycle. outstanding[5] ends at 5-1-1=3.
- Bad ID: c1 rsp with mdata=0xF000 and NUM_SUB_AFUS=9 -> no valid on any port, err_bad_id=1, counters unchanged. It stays 1 until SoftReset.
- Underflow: c0 rsp to AFU 0 with outstanding[0]=0 -> delivered, counter stays 0, err_underflow[0]=1.
- MMIO and almost-full: mmioWrValid=1 -> no downstream activity. c0TxAlmFull=1 -> all 9 ports show c0TxAlmFull=1 one cycle later.
- Reset mid-flight: inject a rsp to AFU 2 and assert SoftReset the next cycle -> no valid ever appears at AFU 2. All outputs are 0 after reset. With VAI_RX_DEMUX_STATS_EN, rsp_count[2]=0.
